oam_dma_arbiter: RTL and testbench



---
 rtl/oam_dma_arbiter_pkg.sv | 35 +++
 rtl/oam_dma_arbiter.sv | 164 ++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// rtl/oam_dma_arbiter_pkg.sv - shared bus types, OAM DMA constants and arbiter state encoding
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } bus_op_t;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } bus_size_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_LEN      = 160;
  localparam logic [7:0]  OAM_LAST     = 8'(OAM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_ISSUE,
    S_CPU_WAIT,
    S_DMA_RD_ISSUE,
    S_DMA_RD_WAIT,
    S_DMA_WR_ISSUE,
    S_DMA_WR_WAIT
  } oam_dma_state_t;

  // Source pages in echo RAM (E0..FF) are read from the WRAM they mirror.
  function automatic logic [7:0] echo_fold(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - owns the MMU request port: forwards CPU accesses and runs OAM DMA
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  bus_op_t     cpu_req_op,
  input  bus_size_t   cpu_req_size,
  input  logic [15:0] cpu_req_addr,
  input  logic [15:0] cpu_req_write_data,
  output logic        cpu_resp_done,
  output logic [15:0] cpu_resp_read_data,
  output bus_op_t     mem_req_op,
  output bus_size_t   mem_req_size,
  output logic [15:0] mem_req_addr,
  output logic [15:0] mem_req_write_data,
  input  logic        mem_resp_done,
  input  logic [15:0] mem_resp_read_data,
  output logic        dma_active
);

  oam_dma_state_t state, state_next;
  logic           trig_pending, trig_pending_next;
  logic [7:0]     src_hi, src_hi_next;
  logic [7:0]     idx, idx_next;
  logic [7:0]     eff_hi;
  logic           hit_lo, hit_hi;

  // Request registers: loaded on entry to an issue state, held through the wait.
  bus_op_t        op_q, op_next;
  bus_size_t      size_q, size_next;
  logic [15:0]    addr_q, addr_next;
  logic [15:0]    wdata_q, wdata_next;

  assign eff_hi = echo_fold(src_hi);
  assign hit_lo = (op_q == WRITE) && (addr_q == DMA_REG_ADDR);
  assign hit_hi = (op_q == WRITE) && (size_q == WORD) && ((addr_q + 16'd1) == DMA_REG_ADDR);

  assign mem_req_size       = size_q;
  assign mem_req_addr       = addr_q;
  assign mem_req_write_data = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      trig_pending <= 1'b0;
      src_hi       <= 8'h00;
      idx          <= 8'h00;
      op_q         <= IDLE;
      size_q       <= BYTE;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      state        <= state_next;
      trig_pending <= trig_pending_next;
      src_hi       <= src_hi_next;
      idx          <= idx_next;
      op_q         <= op_next;
      size_q       <= size_next;
      addr_q       <= addr_next;
      wdata_q      <= wdata_next;
    end
  end

  always_comb begin
    state_next         = state;
    trig_pending_next  = trig_pending;
    src_hi_next        = src_hi;
    idx_next           = idx;
    op_next            = op_q;
    size_next          = size_q;
    addr_next          = addr_q;
    wdata_next         = wdata_q;
    mem_req_op         = IDLE;
    cpu_resp_done      = 1'b0;
    cpu_resp_read_data = 16'h0000;
    dma_active         = 1'b0;

    case (state)
      S_IDLE: begin
        if (cpu_req_op != IDLE) begin
          op_next    = cpu_req_op;
          size_next  = cpu_req_size;
          addr_next  = cpu_req_addr;
          wdata_next = cpu_req_write_data;
          state_next = S_CPU_ISSUE;
        end
      end

      S_CPU_ISSUE: begin
        mem_req_op = op_q;
        if (hit_lo) begin
          trig_pending_next = 1'b1;
          src_hi_next       = wdata_q[7:0];
        end else if (hit_hi) begin
          trig_pending_next = 1'b1;
          src_hi_next       = wdata_q[15:8];
        end
        state_next = S_CPU_WAIT;
      end

      S_CPU_WAIT: begin
        if (mem_resp_done) begin
          cpu_resp_done      = 1'b1;
          cpu_resp_read_data = mem_resp_read_data;
          if (trig_pending) begin
            trig_pending_next = 1'b0;
            idx_next          = 8'h00;
            op_next           = READ;
            size_next         = BYTE;
            addr_next         = {eff_hi, 8'h00};
            wdata_next        = 16'h0000;
            state_next        = S_DMA_RD_ISSUE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_DMA_RD_ISSUE: begin
        dma_active = 1'b1;
        mem_req_op = op_q;
        state_next = S_DMA_RD_WAIT;
      end

      S_DMA_RD_WAIT: begin
        dma_active = 1'b1;
        // The write-data register doubles as the latch for the fetched byte.
        if (mem_resp_done) begin
          op_next    = WRITE;
          size_next  = BYTE;
          addr_next  = OAM_BASE + {8'h00, idx};
          wdata_next = {8'h00, mem_resp_read_data[7:0]};
          state_next = S_DMA_WR_ISSUE;
        end
      end

      S_DMA_WR_ISSUE: begin
        dma_active = 1'b1;
        mem_req_op = op_q;
        state_next = S_DMA_WR_WAIT;
      end

      S_DMA_WR_WAIT: begin
        dma_active = 1'b1;
        if (mem_resp_done) begin
          if (idx == OAM_LAST) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = idx + 8'd1;
            op_next    = READ;
            size_next  = BYTE;
            addr_next  = {eff_hi, idx + 8'd1};
            wdata_next = 16'h0000;
            state_next = S_DMA_RD_ISSUE;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - self-checking bench for oam_dma_arbiter with a 2-cycle MMU model
module tb_oam_dma_arbiter;
  import oam_dma_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  bus_op_t     cpu_req_op;
  bus_size_t   cpu_req_size;
  logic [15:0] cpu_req_addr;
  logic [15:0] cpu_req_write_data;
  logic        cpu_resp_done;
  logic [15:0] cpu_resp_read_data;
  bus_op_t     mem_req_op;
  bus_size_t   mem_req_size;
  logic [15:0] mem_req_addr;
  logic [15:0] mem_req_write_data;
  logic        mem_resp_done;
  logic [15:0] mem_resp_read_data;
  logic        dma_active;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req_op(cpu_req_op), .cpu_req_size(cpu_req_size),
    .cpu_req_addr(cpu_req_addr), .cpu_req_write_data(cpu_req_write_data),
    .cpu_resp_done(cpu_resp_done), .cpu_resp_read_data(cpu_resp_read_data),
    .mem_req_op(mem_req_op), .mem_req_size(mem_req_size),
    .mem_req_addr(mem_req_addr), .mem_req_write_data(mem_req_write_data),
    .mem_resp_done(mem_resp_done), .mem_resp_read_data(mem_resp_read_data),
    .dma_active(dma_active)
  );

  // MMU: samples a request when idle, completes two cycles after the request cycle.
  logic [7:0]  mem     [0:65535] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
  logic        mmu_busy;
  bus_op_t     mmu_op;
  bus_size_t   mmu_size;
  logic [15:0] mmu_addr, mmu_wdata;

  always @(posedge clk) begin
    if (reset) begin
      mmu_busy           <= 1'b0;
      mem_resp_done      <= 1'b0;
      mem_resp_read_data <= 16'h0000;
    end else begin
      mem_resp_done <= 1'b0;
      if (mmu_busy) begin
        mmu_busy      <= 1'b0;
        mem_resp_done <= 1'b1;
        if (mmu_op == READ) begin
          mem_resp_read_data <= (mmu_size == WORD) ? {mem[mmu_addr + 16'd1], mem[mmu_addr]}
                                                   : {8'h00, mem[mmu_addr]};
        end else begin
          mem[mmu_addr] <= mmu_wdata[7:0];
          if (mmu_size == WORD) mem[mmu_addr + 16'd1] <= mmu_wdata[15:8];
        end
      end else if (mem_req_op != IDLE) begin
        mmu_busy  <= 1'b1;
        mmu_op    <= mem_req_op;
        mmu_size  <= mem_req_size;
        mmu_addr  <= mem_req_addr;
        mmu_wdata <= mem_req_write_data;
      end
    end
  end

  // Protocol monitor: op pulses are one cycle, never issued to a busy MMU, CPU stalled during DMA.
  logic prev_active;
  always @(negedge clk) begin
    if (reset) begin
      prev_active <= 1'b0;
    end else begin
      prev_active <= (mem_req_op != IDLE);
      if ((mem_req_op != IDLE) && (prev_active || mmu_busy)) viol <= viol + 1;
      if (cpu_resp_done && dma_active) viol <= viol + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pat(input int kind, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (kind)
      0: return b ^ 8'hA5;
      1: return 8'(i * 3 + 7);
      2: return b ^ 8'h3C;
      3: return b ^ 8'h5A;
      default: return b ^ 8'hC3;
    endcase
  endfunction

  // Reference: a write that covers 0xFF46 copies 160 bytes from the source page (echo folded) into OAM.
  task automatic model_write(input bus_size_t sz, input logic [15:0] a, input logic [15:0] d,
                             output bit trig);
    logic [7:0]  hi;
    logic [15:0] a1, base;
    trig = 1'b0;
    hi   = 8'h00;
    a1   = a + 16'd1;
    ref_mem[a] = d[7:0];
    if (a == 16'hFF46) begin trig = 1'b1; hi = d[7:0]; end
    if (sz == WORD) begin
      ref_mem[a1] = d[15:8];
      if (a1 == 16'hFF46) begin trig = 1'b1; hi = d[15:8]; end
    end
    if (trig) begin
      base = {hi, 8'h00};
      if (base >= 16'hE000) base = base - 16'h2000;
      for (int i = 0; i < 160; i++) ref_mem[16'hFE00 + 16'(i)] = ref_mem[base + 16'(i)];
    end
  endtask

  task automatic cpu_access(input bus_op_t op, input bus_size_t sz, input logic [15:0] a,
                            input logic [15:0] d, input bit use_model,
                            output logic [15:0] rd, output int lat, output bit trig);
    bit got;
    int n;
    cpu_req_op         = op;
    cpu_req_size       = sz;
    cpu_req_addr       = a;
    cpu_req_write_data = d;
    got = 1'b0;
    n   = 0;
    rd  = 16'h0000;
    while (!got && n < 3000) begin
      @(negedge clk);
      if (cpu_resp_done) begin
        got = 1'b1;
        rd  = cpu_resp_read_data;
      end else begin
        n++;
      end
    end
    lat = n;
    if (!got) check($sformatf("cpu_done_timeout_%h", a), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cpu_req_op = IDLE;
    trig = 1'b0;
    if (use_model && op == WRITE) model_write(sz, a, d, trig);
  endtask

  task automatic wait_dma(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!dma_active) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] base, input int kind);
    logic [15:0] rd;
    int lat;
    bit trig;
    for (int i = 0; i < 160; i += 2)
      cpu_access(WRITE, WORD, base + 16'(i), {exp_pat(kind, i + 1), exp_pat(kind, i)}, 1'b1, rd, lat, trig);
  endtask

  task automatic check_oam(input string name, input int kind, input int lo, input int hi);
    int errs;
    errs = 0;
    for (int i = lo; i <= hi; i++)
      if (mem[16'hFE00 + 16'(i)] !== exp_pat(kind, i)) errs++;
    check(name, 64'(errs), 64'd0);
  endtask

  typedef struct {
    bus_op_t     op;
    bus_size_t   sz;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [0:7];
  logic [7:0]  hi_choices [0:3];
  logic [7:0]  old_oam [0:159];
  logic [15:0] rd, exp_rd, a;
  int          lat, n, errs, r;
  bit          trig, found;
  bus_size_t   sz;
  logic [7:0]  hi;

  initial begin
    vecs[0] = '{WRITE, BYTE, 16'hC000, 16'h005A, 16'h0000, 3};
    vecs[1] = '{READ,  BYTE, 16'hC000, 16'h0000, 16'h005A, 3};
    vecs[2] = '{WRITE, WORD, 16'hC100, 16'hBEEF, 16'h0000, 3};
    vecs[3] = '{READ,  WORD, 16'hC100, 16'h0000, 16'hBEEF, 3};
    vecs[4] = '{READ,  BYTE, 16'hC101, 16'h0000, 16'h00BE, 3};
    vecs[5] = '{WRITE, BYTE, 16'hC101, 16'h1277, 16'h0000, 3};
    vecs[6] = '{READ,  WORD, 16'hC100, 16'h0000, 16'h77EF, 3};
    vecs[7] = '{WRITE, BYTE, 16'hFF45, 16'h0012, 16'h0000, 3};
    hi_choices[0] = 8'hC0;
    hi_choices[1] = 8'hC2;
    hi_choices[2] = 8'hD1;
    hi_choices[3] = 8'hE2;

    reset              = 1'b1;
    cpu_req_op         = IDLE;
    cpu_req_size       = BYTE;
    cpu_req_addr       = 16'h0000;
    cpu_req_write_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({mem_req_op, mem_req_size, mem_req_addr, mem_req_write_data,
                                cpu_resp_done, cpu_resp_read_data, dma_active}), 64'd0);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      cpu_access(vecs[k].op, vecs[k].sz, vecs[k].addr, vecs[k].wdata, 1'b1, rd, lat, trig);
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
      if (vecs[k].op == READ) check($sformatf("vec%0d_rdata", k), 64'(rd), 64'(vecs[k].exp_rd));
      check($sformatf("vec%0d_dma_idle", k), 64'(dma_active), 64'd0);
    end
    cpu_access(READ, WORD, 16'hFF45, 16'h0000, 1'b1, rd, lat, trig);
    check("ff45_byte_no_trigger", 64'(rd), 64'h0012);

    preload(16'hC000, 0);
    cpu_access(WRITE, BYTE, 16'hFF46, 16'h00C0, 1'b1, rd, lat, trig);
    check("trig_write_latency", 64'(lat), 64'd3);
    wait_dma(n);
    check("dma_active_cycles", 64'(n), 64'd960);
    check_oam("oam_copy_c0", 0, 0, 159);
    cpu_access(READ, BYTE, 16'hFF46, 16'h0000, 1'b1, rd, lat, trig);
    check("ff46_readback", 64'(rd), 64'h00C0);

    cpu_access(WRITE, BYTE, 16'hFF46, 16'h00C0, 1'b1, rd, lat, trig);
    cpu_access(READ, BYTE, 16'hC010, 16'h0000, 1'b1, rd, lat, trig);
    check("held_read_latency", 64'(lat), 64'd963);
    check("held_read_data", 64'(rd), 64'h00B5);

    preload(16'hD100, 1);
    cpu_access(WRITE, WORD, 16'hFF45, 16'hD133, 1'b1, rd, lat, trig);
    wait_dma(n);
    check("word_trig_cycles", 64'(n), 64'd960);
    check("word_trig_fe9f", 64'(mem[16'hFE9F]), 64'(exp_pat(1, 159)));
    check_oam("oam_copy_d1", 1, 0, 159);
    check("word_trig_ff45", 64'(mem[16'hFF45]), 64'h33);

    preload(16'hC200, 2);
    preload(16'hE200, 4);
    cpu_access(WRITE, BYTE, 16'hFF46, 16'h00E2, 1'b1, rd, lat, trig);
    wait_dma(n);
    check_oam("oam_echo_fold_e2", 2, 0, 159);

    for (int k = 0; k < 48; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        hi = hi_choices[$urandom_range(0, 3)];
        if ($urandom_range(0, 1) == 1) cpu_access(WRITE, BYTE, 16'hFF46, {8'h00, hi}, 1'b1, rd, lat, trig);
        else cpu_access(WRITE, WORD, 16'hFF45, {hi, 8'($urandom)}, 1'b1, rd, lat, trig);
        check($sformatf("rnd%0d_trig_seen", k), 64'(trig), 64'd1);
        wait_dma(n);
        check($sformatf("rnd%0d_dma_cycles", k), 64'(n), 64'd960);
      end else begin
        a  = 16'hC000 + 16'($urandom_range(0, 16'h02FE));
        sz = ($urandom_range(0, 1) == 1) ? WORD : BYTE;
        if (r < 55) begin
          exp_rd = (sz == WORD) ? {ref_mem[a + 16'd1], ref_mem[a]} : {8'h00, ref_mem[a]};
          cpu_access(READ, sz, a, 16'h0000, 1'b1, rd, lat, trig);
          check($sformatf("rnd%0d_rdata_%h", k, a), 64'(rd), 64'(exp_rd));
        end else begin
          cpu_access(WRITE, sz, a, 16'($urandom), 1'b1, rd, lat, trig);
        end
        check($sformatf("rnd%0d_latency", k), 64'(lat), 64'd3);
      end
    end
    errs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) errs++;
    check("mem_vs_model", 64'(errs), 64'd0);

    preload(16'hC000, 3);
    for (int i = 0; i < 160; i++) old_oam[i] = ref_mem[16'hFE00 + 16'(i)];
    cpu_access(WRITE, BYTE, 16'hFF46, 16'h00C0, 1'b0, rd, lat, trig);
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (mem_req_op == READ && mem_req_addr == 16'hC050) found = 1'b1;
    end
    check("reach_byte80", 64'(found), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_outputs", 64'({mem_req_op, mem_req_size, mem_req_addr, mem_req_write_data,
                                   cpu_resp_done, cpu_resp_read_data, dma_active}), 64'd0);
    reset = 1'b0;
    check_oam("midreset_copied_lo", 3, 0, 79);
    errs = 0;
    for (int i = 80; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== old_oam[i]) errs++;
    check("midreset_untouched_hi", 64'(errs), 64'd0);
    cpu_access(READ, BYTE, 16'hC010, 16'h0000, 1'b0, rd, lat, trig);
    check("post_reset_read_data", 64'(rd), 64'h004A);
    check("post_reset_read_latency", 64'(lat), 64'd3);

    check("monitor_violations", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
